// File: rtl/gate_test_seq_pkg.sv
// Shared types and constants for the gate test sequencer: FSM states,
// LFSR taps and MISR polynomial/seed.
package gate_test_seq_pkg;
    localparam int LFSR_W      = 11;
    localparam int MISR_W      = 16;
    localparam int DOUT_W      = 10;
    localparam int LFSR_TAP_HI = 10;
    localparam int LFSR_TAP_LO = 8;

    localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;
    localparam logic [MISR_W-1:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction
endpackage

// File: rtl/gate_test_seq_if.sv
// Control and gate-model bus of the sequencer. With GATE_TEST_SEQ_CHECK_EN
// defined it also carries the expected signature and the pass flag.
interface gate_test_seq_if;
    import gate_test_seq_pkg::*;

    logic                start;
    logic                abort;
    logic [LFSR_W-1:0]   dut_in;
    logic [DOUT_W-1:0]   dut_out;
    logic                busy;
    logic                done;
    logic [MISR_W-1:0]   signature;
    logic [15:0]         pat_cnt;
`ifdef GATE_TEST_SEQ_CHECK_EN
    logic [MISR_W-1:0]   expected;
    logic                pass;

    modport master (output start, abort, dut_out, expected,
                    input  dut_in, busy, done, signature, pat_cnt, pass);
    modport slave  (input  start, abort, dut_out, expected,
                    output dut_in, busy, done, signature, pat_cnt, pass);
`else
    modport master (output start, abort, dut_out,
                    input  dut_in, busy, done, signature, pat_cnt);
    modport slave  (input  start, abort, dut_out,
                    output dut_in, busy, done, signature, pat_cnt);
`endif
endinterface

// File: rtl/gate_test_seq_misr.sv
// 16-bit MISR compacting the 10-bit gate response; nxt is the value the
// register takes on a step, exposed so the top can latch it alongside.
module gate_test_misr
    import gate_test_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DOUT_W-1:0] data,
    output logic [MISR_W-1:0] nxt
);
    logic [MISR_W-1:0] misr_q, misr_d;

    always_comb begin
        nxt = {misr_q[MISR_W-2:0], 1'b0}
            ^ (misr_q[MISR_W-1] ? MISR_POLY : '0)
            ^ {{(MISR_W-DOUT_W){1'b0}}, data};
        misr_d = misr_q;
        if (load)      misr_d = MISR_SEED;
        else if (step) misr_d = nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) misr_q <= MISR_SEED;
        else     misr_q <= misr_d;
    end
endmodule

// File: rtl/gate_test_seq.sv
// Pattern sequencer: LFSR stimulus into a gate model, MISR over its outputs.
// Optional GATE_TEST_SEQ_CHECK_EN adds an expected-signature compare (pass).
module gate_test_seq
    import gate_test_seq_pkg::*;
#(
    parameter int                NUM_PATTERNS  = 1024,
    parameter int                SETTLE_CYCLES = 2,
    parameter logic [LFSR_W-1:0] SEED          = 11'h001
) (
    input logic           clk,
    input logic           rst,
    gate_test_seq_if.slave io
);
    localparam logic [3:0]  SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [16:0] PAT_TOTAL   = 17'(NUM_PATTERNS);

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [15:0]       pat_cnt_q, pat_cnt_d;
    logic [3:0]        settle_q, settle_d;
    logic [MISR_W-1:0] signature_q, signature_d;
    logic              misr_load, misr_step;
    logic [MISR_W-1:0] misr_nxt;
    logic              busy;
    logic              last_pat;
`ifdef GATE_TEST_SEQ_CHECK_EN
    logic              pass_q, pass_d;
`endif

    assign busy     = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    assign last_pat = ({1'b0, pat_cnt_q} + 17'd1) == PAT_TOTAL;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        pat_cnt_d   = pat_cnt_q;
        settle_d    = settle_q;
        signature_d = signature_q;
        misr_load   = 1'b0;
        misr_step   = 1'b0;
`ifdef GATE_TEST_SEQ_CHECK_EN
        pass_d      = pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (io.start) begin
                    state_d   = ST_APPLY;
                    lfsr_d    = SEED;
                    pat_cnt_d = '0;
                    settle_d  = '0;
                    misr_load = 1'b1;
`ifdef GATE_TEST_SEQ_CHECK_EN
                    pass_d    = 1'b0;
`endif
                end
            end
            ST_APPLY: begin
                settle_d = '0;
                state_d  = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CAPTURE;
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d  = ST_CAPTURE;
                else                         settle_d = settle_q + 4'd1;
            end
            ST_CAPTURE: begin
                misr_step = 1'b1;
                lfsr_d    = lfsr_step(lfsr_q);
                pat_cnt_d = pat_cnt_q + 16'd1;
                if (last_pat) begin
                    // latch the final MISR value so it is already valid during DONE
                    state_d     = ST_DONE;
                    signature_d = misr_nxt;
`ifdef GATE_TEST_SEQ_CHECK_EN
                    pass_d      = (misr_nxt == io.expected);
`endif
                end else begin
                    state_d = ST_APPLY;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // abort wins over every transition and discards the partial capture
        if (io.abort && busy) begin
            state_d     = ST_IDLE;
            lfsr_d      = lfsr_q;
            pat_cnt_d   = pat_cnt_q;
            settle_d    = settle_q;
            signature_d = signature_q;
            misr_step   = 1'b0;
`ifdef GATE_TEST_SEQ_CHECK_EN
            pass_d      = pass_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= SEED;
            pat_cnt_q   <= '0;
            settle_q    <= '0;
            signature_q <= '0;
`ifdef GATE_TEST_SEQ_CHECK_EN
            pass_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            pat_cnt_q   <= pat_cnt_d;
            settle_q    <= settle_d;
            signature_q <= signature_d;
`ifdef GATE_TEST_SEQ_CHECK_EN
            pass_q      <= pass_d;
`endif
        end
    end

    gate_test_misr u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (misr_load),
        .step (misr_step),
        .data (io.dut_out),
        .nxt  (misr_nxt)
    );

    assign io.busy      = busy;
    assign io.done      = (state_q == ST_DONE);
    assign io.dut_in    = busy ? lfsr_q : '0;
    assign io.signature = signature_q;
    assign io.pat_cnt   = pat_cnt_q;
`ifdef GATE_TEST_SEQ_CHECK_EN
    assign io.pass      = pass_q;
`endif
endmodule

// File: tb/tb_gate_test_seq.sv
// Bench for gate_test_seq: three configurations, signature scoreboard fed by
// an independent LFSR/MISR/gate reference model.
module tb_gate_test_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gate_test_seq_if ia ();
    gate_test_seq_if ib ();
    gate_test_seq_if ic ();

    gate_test_seq #(.NUM_PATTERNS(1),    .SETTLE_CYCLES(0)) u_a (.clk(clk), .rst(rst), .io(ia.slave));
    gate_test_seq #(.NUM_PATTERNS(4),    .SETTLE_CYCLES(2)) u_b (.clk(clk), .rst(rst), .io(ib.slave));
    gate_test_seq #(.NUM_PATTERNS(1024), .SETTLE_CYCLES(1)) u_c (.clk(clk), .rst(rst), .io(ic.slave));

    // reference gate model: arbitrary 11-in / 10-out mix of gates
    function automatic logic [9:0] gate_fn(input logic [10:0] n);
        logic [9:0] o;
        o[0] = ~(n[0] & n[2]);
        o[1] = ~(n[1] | n[3]);
        o[2] = n[4] ^ n[5];
        o[3] = ~(n[6] & n[7] & n[8]);
        o[4] = n[9] | n[10];
        o[5] = (n[0] & n[10]) | n[5];
        o[6] = ~(n[2] ^ n[8]);
        o[7] = n[1] & n[6] & ~n[9];
        o[8] = ^n[10:7];
        o[9] = ~|n[3:0];
        return o;
    endfunction

    function automatic logic [15:0] model_sig(input int n, input bit use_gate);
        logic [10:0] l;
        logic [15:0] m;
        logic [9:0]  o;
        l = 11'h001;
        m = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            o = use_gate ? gate_fn(l) : 10'h000;
            m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {6'b0, o};
            l = {l[9:0], l[10] ^ l[8]};
        end
        return m;
    endfunction

    assign ia.dut_out = '0;
    assign ib.dut_out = gate_fn(ib.dut_in);
    assign ic.dut_out = gate_fn(ic.dut_in);
`ifdef GATE_TEST_SEQ_CHECK_EN
    assign ia.expected = '0;
    assign ib.expected = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] pat_q[$];
    logic [31:0] sig_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_sig(input string tag, input logic [31:0] got);
        if (sig_q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
        else                   chk(tag, got, sig_q.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int          done_cyc, done_n, busy_cnt;
        logic [10:0] l;
        logic [15:0] sig_b, sig_c;

        rst = 1'b1;
        ia.start = 0; ia.abort = 0;
        ib.start = 0; ib.abort = 0;
        ic.start = 0; ic.abort = 0;
`ifdef GATE_TEST_SEQ_CHECK_EN
        ic.expected = '0;
`endif
        tick; tick;
        chk("rst_busy",    32'(ib.busy),      0);
        chk("rst_done",    32'(ib.done),      0);
        chk("rst_dut_in",  32'(ib.dut_in),    0);
        chk("rst_sig",     32'(ib.signature), 0);
        chk("rst_pat_cnt", 32'(ib.pat_cnt),   0);
        rst = 1'b0;
        tick;

        // one pattern, no settle, zero response
        sig_q.push_back(32'h0000EFDF);
        ia.start = 1; tick; ia.start = 0;
        done_cyc = 0;
        for (int c = 1; c <= 6; c++) begin
            if (ia.done && done_cyc == 0) begin
                done_cyc = c;
                pop_sig("a_sig", 32'(ia.signature));
            end
            tick;
        end
        chk("a_latency",  done_cyc, 3);
        chk("a_sig_hold", 32'(ia.signature), 32'h0000EFDF);
        chk("a_idle_din", 32'(ia.dut_in), 0);
        sig_q.delete();

        // four patterns, settle 2; start pulses while busy and in DONE
        l = 11'h001;
        for (int i = 0; i < 4; i++) begin
            pat_q.push_back({5'd0, l, 16'(i)});
            l = {l[9:0], l[10] ^ l[8]};
        end
        sig_b = model_sig(4, 1'b1);
        sig_q.push_back(32'(sig_b));
        ib.start = 1; tick; ib.start = 0;
        done_cyc = 0; done_n = 0; busy_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            ib.start = (c == 3 || c == 8 || c == 17);
            if (ib.busy) busy_cnt++;
            if (ib.done) begin
                done_n++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    pop_sig("b_sig", 32'(ib.signature));
                end
            end
            if (c % 4 == 1 && c <= 13) begin
                if (pat_q.size() == 0) chk("b_pat_sb_empty", 1, 0);
                else chk("b_apply_pat", {5'd0, ib.dut_in, ib.pat_cnt}, pat_q.pop_front());
            end
            tick;
        end
        ib.start = 0;
        chk("b_busy_cycles", busy_cnt, 16);
        chk("b_latency",     done_cyc, 17);
        chk("b_done_pulses", done_n,   1);
        chk("b_pat_cnt_end", 32'(ib.pat_cnt),   4);
        chk("b_sig_hold",    32'(ib.signature), 32'(sig_b));
        sig_q.delete();

        // abort in the second SETTLE cycle
        ib.start = 1; tick; ib.start = 0;
        tick; tick;
        ib.abort = 1; tick; ib.abort = 0;
        chk("abort_busy",   32'(ib.busy),      0);
        chk("abort_done",   32'(ib.done),      0);
        chk("abort_dut_in", 32'(ib.dut_in),    0);
        chk("abort_sig",    32'(ib.signature), 32'(sig_b));
        done_n = 0;
        for (int c = 0; c < 20; c++) begin
            if (ib.done) done_n++;
            tick;
        end
        chk("abort_no_done", done_n, 0);
        sig_q.push_back(32'(sig_b));
        ib.start = 1; tick; ib.start = 0;
        done_cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            if (ib.done && done_cyc == 0) begin
                done_cyc = c;
                pop_sig("abort_rerun_sig", 32'(ib.signature));
            end
            tick;
        end
        chk("abort_rerun_latency", done_cyc, 17);
        sig_q.delete();

        // full 1024-pattern run against the reference model, twice
        sig_c = model_sig(1024, 1'b1);
        for (int r = 0; r < 2; r++) begin
            sig_q.push_back(32'(sig_c));
`ifdef GATE_TEST_SEQ_CHECK_EN
            ic.expected = (r == 0) ? sig_c : (sig_c ^ 16'h0001);
`endif
            ic.start = 1; tick; ic.start = 0;
`ifdef GATE_TEST_SEQ_CHECK_EN
            chk("c_pass_cleared", 32'(ic.pass), 0);
`endif
            done_cyc = 0;
            for (int c = 1; c <= 3200; c++) begin
                if (ic.done && done_cyc == 0) begin
                    done_cyc = c;
                    pop_sig("c_sig", 32'(ic.signature));
                end
                tick;
                if (done_cyc != 0) break;
            end
            chk("c_latency", done_cyc, 1024 * 3 + 1);
`ifdef GATE_TEST_SEQ_CHECK_EN
            chk("c_pass", 32'(ic.pass), (r == 0) ? 1 : 0);
`endif
            sig_q.delete();
        end

        // reset in the first CAPTURE beats abort and start
        ib.start = 1; tick; ib.start = 0;
        tick; tick; tick;
        chk("r_busy_pre", 32'(ib.busy), 1);
        rst = 1; ib.abort = 1; ib.start = 1;
        tick;
        chk("r_busy",    32'(ib.busy),      0);
        chk("r_done",    32'(ib.done),      0);
        chk("r_dut_in",  32'(ib.dut_in),    0);
        chk("r_sig",     32'(ib.signature), 0);
        chk("r_pat_cnt", 32'(ib.pat_cnt),   0);
        rst = 0; ib.abort = 0; ib.start = 0;
        tick;
        chk("r_idle_after", 32'(ib.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_test_seq.md
GATE_TEST_SEQ -- requirements
Module: gate_test_seq

Interface
REQ-001 Parameter NUM_PATTERNS, default 1024: patterns applied per run; legal range 1..65535.
REQ-002 Parameter SETTLE_CYCLES, default 2: wait cycles between applying a pattern and capturing; legal range 0..15.
REQ-003 Parameter SEED, default 11'h001: LFSR start value; must be non-zero.
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port start, input, 1: single-cycle run request; sampled only in IDLE.
REQ-007 Port abort, input, 1: terminate the run and return to IDLE.
REQ-008 Port dut_in, output, 11: stimulus to the 11-input gate model (bit 0 = N1).
REQ-009 Port dut_out, input, 10: gate model outputs, packed in the team's output order.
REQ-010 Port busy, output, 1: high in every state except IDLE and DONE.
REQ-011 Port done, output, 1: one-cycle pulse on run completion.
REQ-012 Port signature, output, 16: MISR result; stable from done until the next accepted start.
REQ-013 Port pat_cnt, output, 16: number of patterns captured so far in the current run.

Function
REQ-014 FSM states: IDLE, APPLY, SETTLE, CAPTURE, DONE.
REQ-015 IDLE & start -> APPLY: load LFSR=SEED, MISR=16'hFFFF, pat_cnt=0, settle counter=0.
REQ-016 APPLY (1 cycle): drive dut_in=LFSR; -> SETTLE if SETTLE_CYCLES>0, else -> CAPTURE.
REQ-017 SETTLE: hold dut_in; count SETTLE_CYCLES cycles, then -> CAPTURE.
REQ-018 CAPTURE (1 cycle): MISR_next = {MISR[14:0],0} ^ (MISR[15] ? 16'h1021 : 0) ^ {6'b0,dut_out}.
REQ-019 CAPTURE also: LFSR_next = {LFSR[9:0], LFSR[10]^LFSR[8]}; pat_cnt+1.
REQ-020 CAPTURE exit: -> DONE if pat_cnt+1==NUM_PATTERNS, else -> APPLY.
REQ-021 DONE (1 cycle): done=1, signature=MISR; -> IDLE.
REQ-022 Latency from the start cycle to the done cycle is exactly NUM_PATTERNS*(SETTLE_CYCLES+2)+1 cycles.
REQ-023 start is ignored when not in IDLE; start in the DONE cycle is also ignored.
REQ-024 abort in any busy state -> IDLE next cycle; no done pulse; signature keeps its previous value; abort has priority over state transitions.
REQ-025 dut_in = 0 in IDLE and DONE.

Reset
REQ-026 rst=1 -> state IDLE; dut_in=0, busy=0, done=0, signature=0, pat_cnt=0, LFSR=SEED, MISR=16'hFFFF.
REQ-027 rst mid-run has priority over abort and start; the run is discarded.

Configuration
REQ-028 Macro GATE_TEST_SEQ_CHECK_EN defined: add input expected[15:0] and output pass[0:0].
REQ-029 With the macro, pass is registered in DONE as (MISR==expected), cleared to 0 by reset and by an accepted start.
REQ-030 Without the macro, the expected and pass ports and their logic are absent; all other behaviour is identical.

Structure
REQ-031 Package gate_test_seq_pkg holds: the FSM state enum, LFSR tap constants, MISR polynomial 16'h1021, MISR seed 16'hFFFF.
REQ-032 Sub-module gate_test_misr implements the 16-bit MISR (load, step, 10-bit data in); the LFSR stays inline.

Verification
REQ-033 NUM_PATTERNS=1, SETTLE=0, dut_out=0, start -> done 3 cycles later, signature=16'hEFDF.
REQ-034 SEED=1 -> dut_in in successive APPLY states = 11'h001, 11'h002, 11'h004; pat_cnt steps 0->1->2.
REQ-035 NUM_PATTERNS=4, SETTLE=2 -> busy high for exactly 16 cycles, done at cycle 17 after start, start pulses during busy ignored.
REQ-036 abort in the 2nd SETTLE cycle -> IDLE next cycle, no done pulse, signature unchanged; a following start gives a normal run.
REQ-037 Gate model connected, NUM_PATTERNS=1024 -> signature equals the bench reference model; with GATE_TEST_SEQ_CHECK_EN, pass=1 for the correct expected value and 0 for expected^1.
REQ-038 rst asserted mid-CAPTURE -> all outputs at reset values on the next cycle.
